// File: rtl/flush_sequencer_pkg.sv
// Shared types, defaults and width helpers for the flush sequencer slice.
package flush_sequencer_pkg;

  // Cache flush controller states
  typedef enum logic [1:0] {
    IDLE,
    FLUSH_PAR,
    FLUSH_SEQ
  } flush_state_e;

  // Default channel count: D$ (index 0) and L2 (index 1)
  localparam int unsigned DefaultNrCacheChans = 2;

  // Width of the pending-channel mask for the default configuration
  localparam int unsigned DefaultMaskWidth = DefaultNrCacheChans;

  // Branch resolution record from the execute stage; only is_mispredict matters here
  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] target_address;
    logic        is_mispredict;
    logic        is_taken;
  } bp_resolve_t;

  // Bits needed to index a channel; never below one so single-channel builds stay legal
  function automatic int unsigned idx_width(input int unsigned nr_chans);
    return (nr_chans > 1) ? $clog2(nr_chans) : 1;
  endfunction

  // Bits needed to count up to the timeout limit inclusive
  function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

  // Default index width derived from the default channel count
  localparam int unsigned DefaultIdxWidth = idx_width(DefaultNrCacheChans);

endpackage

// File: rtl/flush_sequencer_cache_flush_fsm.sv
// Write-back cache flush sequencer: walks the flush channels in parallel or one
// at a time, tracks acknowledges and optionally aborts on an acknowledge timeout.
module cache_flush_fsm
  import flush_sequencer_pkg::*;
#(
  parameter int unsigned NrCacheChans  = DefaultNrCacheChans,
  parameter int unsigned SeqMode       = 0,
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [NrCacheChans-1:0] ack_i,
  output logic [NrCacheChans-1:0] flush_cache_o,
  output logic                    busy_o,
  output logic                    timeout_o
);

  localparam int unsigned IdxWidth = idx_width(NrCacheChans);
  localparam int unsigned CntWidth = cnt_width(TimeoutCycles);
  localparam logic [NrCacheChans-1:0] AllChans  = {NrCacheChans{1'b1}};
  localparam logic [NrCacheChans-1:0] FirstChan = NrCacheChans'(1);
  localparam logic [IdxWidth-1:0]     LastIdx   = IdxWidth'(NrCacheChans - 1);
  localparam logic [CntWidth-1:0]     CntLimit  = CntWidth'(TimeoutCycles);
  localparam bit                      TimeoutEn = (TimeoutCycles != 0);

  flush_state_e            state;
  logic [NrCacheChans-1:0] pending;
  logic [IdxWidth-1:0]     index;
  logic [CntWidth-1:0]     count;

  logic [NrCacheChans-1:0] seq_sel;
  logic [NrCacheChans-1:0] pending_left;
  logic [CntWidth-1:0]     count_inc;
  logic                    ack_hit;
  logic                    expired;

  assign busy_o = (state != IDLE);

  // Decode which acknowledges count this cycle and whether the wait has run out
  always_comb begin
    seq_sel      = FirstChan << index;
    pending_left = pending & ~ack_i;
    ack_hit      = 1'b0;
    case (state)
      FLUSH_PAR: ack_hit = |(ack_i & pending);
      FLUSH_SEQ: ack_hit = |(ack_i & seq_sel);
      default:   ack_hit = 1'b0;
    endcase
    expired   = TimeoutEn && (state != IDLE) && (count == CntLimit) && !ack_hit;
    count_inc = TimeoutEn ? count + 1'b1 : '0;
  end

  // Sequencer state, channel bookkeeping and registered request/timeout outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      pending       <= '0;
      index         <= '0;
      count         <= '0;
      flush_cache_o <= '0;
      timeout_o     <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            count <= '0;
            index <= '0;
            if (SeqMode == 0) begin
              state         <= FLUSH_PAR;
              pending       <= AllChans;
              flush_cache_o <= AllChans;
            end else begin
              state         <= FLUSH_SEQ;
              pending       <= '0;
              flush_cache_o <= FirstChan;
            end
          end
        end

        FLUSH_PAR: begin
          if (expired) begin
            state         <= IDLE;
            pending       <= '0;
            index         <= '0;
            count         <= '0;
            flush_cache_o <= '0;
            timeout_o     <= 1'b1;
          end else begin
            pending       <= pending_left;
            flush_cache_o <= pending_left;
            count         <= count_inc;
            if (pending_left == '0) begin
              state <= IDLE;
              count <= '0;
            end
          end
        end

        FLUSH_SEQ: begin
          if (expired) begin
            state         <= IDLE;
            pending       <= '0;
            index         <= '0;
            count         <= '0;
            flush_cache_o <= '0;
            timeout_o     <= 1'b1;
          end else if (ack_hit) begin
            count <= '0;
            if (index == LastIdx) begin
              state         <= IDLE;
              index         <= '0;
              flush_cache_o <= '0;
            end else begin
              index         <= index + 1'b1;
              flush_cache_o <= seq_sel << 1;
            end
          end else begin
            count <= count_inc;
          end
        end

        default: begin
          state         <= IDLE;
          pending       <= '0;
          index         <= '0;
          count         <= '0;
          flush_cache_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/flush_sequencer.sv
// Pipeline flush controller: turns fences, exceptions, CSR side effects and
// mispredicts into flush strobes and drives the write-back cache flush sequencer.
module flush_sequencer
  import flush_sequencer_pkg::*;
#(
  parameter int unsigned NrCacheChans  = DefaultNrCacheChans,
  parameter int unsigned WtDcache      = 0,
  parameter int unsigned SeqMode       = 0,
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    v_i,
  input  bp_resolve_t             resolved_branch_i,
  input  logic                    fence_i,
  input  logic                    fence_i_i,
  input  logic                    sfence_vma_i,
  input  logic                    hfence_vvma_i,
  input  logic                    hfence_gvma_i,
  input  logic                    flush_csr_i,
  input  logic                    flush_commit_i,
  input  logic                    ex_valid_i,
  input  logic                    eret_i,
  input  logic                    set_debug_pc_i,
  input  logic                    halt_csr_i,
  input  logic [NrCacheChans-1:0] flush_cache_ack_i,
  output logic                    set_pc_commit_o,
  output logic                    flush_if_o,
  output logic                    flush_unissued_instr_o,
  output logic                    flush_id_o,
  output logic                    flush_ex_o,
  output logic                    flush_bp_o,
  output logic                    flush_icache_o,
  output logic                    flush_tlb_o,
  output logic                    flush_tlb_vvma_o,
  output logic                    flush_tlb_gvma_o,
  output logic [NrCacheChans-1:0] flush_cache_o,
  output logic                    halt_o,
  output logic                    fence_busy_o,
  output logic                    flush_timeout_o
);

  logic pipe_flush;
  logic exc_flush;
  logic cache_start;
  logic cache_busy;
  logic unused_bp_fields;

  // Any commit-side event that restarts fetch at the next PC
  assign pipe_flush = fence_i | fence_i_i | sfence_vma_i | hfence_vvma_i |
                      hfence_gvma_i | flush_csr_i | flush_commit_i;

  // Trap-like events that redirect to a new PC and also clear the predictor
  assign exc_flush = ex_valid_i | eret_i | set_debug_pc_i;

  // Write-through hierarchies have nothing dirty to write back
  assign cache_start = (WtDcache == 0) && (fence_i | fence_i_i);

  // Only the mispredict flag of the resolution record is consumed
  assign unused_bp_fields = ^resolved_branch_i;

  // Combinational flush matrix, OR-combined across all sources
  always_comb begin
    set_pc_commit_o        = 1'b0;
    flush_if_o             = 1'b0;
    flush_unissued_instr_o = 1'b0;
    flush_id_o             = 1'b0;
    flush_ex_o             = 1'b0;
    flush_bp_o             = 1'b0;
    flush_icache_o         = 1'b0;
    flush_tlb_o            = 1'b0;
    flush_tlb_vvma_o       = 1'b0;
    flush_tlb_gvma_o       = 1'b0;

    if (resolved_branch_i.is_mispredict) begin
      flush_if_o             = 1'b1;
      flush_unissued_instr_o = 1'b1;
    end

    if (pipe_flush) begin
      set_pc_commit_o        = 1'b1;
      flush_if_o             = 1'b1;
      flush_unissued_instr_o = 1'b1;
      flush_id_o             = 1'b1;
      flush_ex_o             = 1'b1;
    end

    if (fence_i_i) begin
      flush_icache_o = 1'b1;
    end

    if (sfence_vma_i) begin
      if (v_i) begin
        flush_tlb_vvma_o = 1'b1;
      end else begin
        flush_tlb_o = 1'b1;
      end
    end

    if (hfence_vvma_i) begin
      flush_tlb_vvma_o = 1'b1;
    end

    if (hfence_gvma_i) begin
      flush_tlb_gvma_o = 1'b1;
    end

    if (exc_flush) begin
      set_pc_commit_o        = 1'b0;
      flush_if_o             = 1'b1;
      flush_unissued_instr_o = 1'b1;
      flush_id_o             = 1'b1;
      flush_ex_o             = 1'b1;
      flush_bp_o             = 1'b1;
    end
  end

  cache_flush_fsm #(
    .NrCacheChans  (NrCacheChans),
    .SeqMode       (SeqMode),
    .TimeoutCycles (TimeoutCycles)
  ) i_cache_flush_fsm (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (cache_start),
    .ack_i         (flush_cache_ack_i),
    .flush_cache_o (flush_cache_o),
    .busy_o        (cache_busy),
    .timeout_o     (flush_timeout_o)
  );

  assign fence_busy_o = cache_busy;
  assign halt_o       = halt_csr_i | cache_busy;

endmodule

// File: tb/tb_flush_sequencer.sv
// Testbench for flush_sequencer: five configurations side by side, a vector
// table for the flush matrix, directed timelines and a randomized model check.
module tb_flush_sequencer;
  import flush_sequencer_pkg::*;

  localparam int NI  = 5;
  localparam int NCH = 2;
  localparam int CFG_SEQ [NI] = '{0, 1, 0, 0, 1};
  localparam int CFG_TO  [NI] = '{0, 0, 4, 0, 3};
  localparam int CFG_WT  [NI] = '{0, 0, 0, 1, 0};

  localparam logic [1:0] A_FC0  [8] = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd1, 2'd1, 2'd0, 2'd0};
  localparam logic       A_HLT0 [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [1:0] A_FC2  [8] = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
  localparam logic       A_TO2  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [1:0] A_FC4  [8] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
  localparam logic       A_TO4  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [1:0] C_FC1  [9] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
  localparam logic [1:0] C_FC0  [5] = '{2'd0, 2'd3, 2'd0, 2'd0, 2'd3};

  typedef struct packed {
    logic v, misp, fence, fencei, sfence, hvvma, hgvma, csr, commit, ex, eret, dbg, haltcsr;
  } vin_t;

  typedef struct {
    vin_t       in;
    logic [9:0] exp;
  } vec_t;

  logic clk, rst_n, v, fence, fence_i, sfence, hvvma, hgvma;
  logic flush_csr, flush_commit, ex_valid, eret, set_debug_pc, halt_csr;
  bp_resolve_t rb;
  logic [NCH-1:0] ack [NI];

  logic set_pc_commit [NI], flush_if [NI], flush_unissued [NI], flush_id [NI];
  logic flush_ex [NI], flush_bp [NI], flush_icache [NI], flush_tlb [NI];
  logic flush_tlb_vvma [NI], flush_tlb_gvma [NI], halt [NI], fence_busy [NI];
  logic flush_timeout [NI];
  logic [NCH-1:0] flush_cache [NI];

  int checks   = 0;
  int failures = 0;

  vec_t vecs [18];

  bit       mbusy [NI];
  logic [1:0] mpend [NI];
  int       mcur  [NI];
  int       mwait [NI];
  bit       mto   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    flush_sequencer #(
      .NrCacheChans  (NCH),
      .WtDcache      (CFG_WT[g]),
      .SeqMode       (CFG_SEQ[g]),
      .TimeoutCycles (CFG_TO[g])
    ) dut (
      .clk_i                  (clk),
      .rst_ni                 (rst_n),
      .v_i                    (v),
      .resolved_branch_i      (rb),
      .fence_i                (fence),
      .fence_i_i              (fence_i),
      .sfence_vma_i           (sfence),
      .hfence_vvma_i          (hvvma),
      .hfence_gvma_i          (hgvma),
      .flush_csr_i            (flush_csr),
      .flush_commit_i         (flush_commit),
      .ex_valid_i             (ex_valid),
      .eret_i                 (eret),
      .set_debug_pc_i         (set_debug_pc),
      .halt_csr_i             (halt_csr),
      .flush_cache_ack_i      (ack[g]),
      .set_pc_commit_o        (set_pc_commit[g]),
      .flush_if_o             (flush_if[g]),
      .flush_unissued_instr_o (flush_unissued[g]),
      .flush_id_o             (flush_id[g]),
      .flush_ex_o             (flush_ex[g]),
      .flush_bp_o             (flush_bp[g]),
      .flush_icache_o         (flush_icache[g]),
      .flush_tlb_o            (flush_tlb[g]),
      .flush_tlb_vvma_o       (flush_tlb_vvma[g]),
      .flush_tlb_gvma_o       (flush_tlb_gvma[g]),
      .flush_cache_o          (flush_cache[g]),
      .halt_o                 (halt[g]),
      .fence_busy_o           (fence_busy[g]),
      .flush_timeout_o        (flush_timeout[g])
    );
  end

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    v = 0; fence = 0; fence_i = 0; sfence = 0; hvvma = 0; hgvma = 0;
    flush_csr = 0; flush_commit = 0; ex_valid = 0; eret = 0; set_debug_pc = 0;
    halt_csr = 0; rb = '0;
    for (int i = 0; i < NI; i++) ack[i] = '0;
  endtask

  task automatic applyStimulus(input vin_t x);
    v = x.v; rb.is_mispredict = x.misp; fence = x.fence; fence_i = x.fencei;
    sfence = x.sfence; hvvma = x.hvvma; hgvma = x.hgvma; flush_csr = x.csr;
    flush_commit = x.commit; ex_valid = x.ex; eret = x.eret; set_debug_pc = x.dbg;
    halt_csr = x.haltcsr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    clearInputs();
    #1 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    for (int i = 0; i < NI; i++) begin
      mbusy[i] = 0; mpend[i] = '0; mcur[i] = 0; mwait[i] = 0; mto[i] = 0;
    end
  endtask

  function automatic logic [9:0] combOut(input int i);
    return {set_pc_commit[i], flush_if[i], flush_unissued[i], flush_id[i], flush_ex[i],
            flush_bp[i], flush_icache[i], flush_tlb[i], flush_tlb_vvma[i], flush_tlb_gvma[i]};
  endfunction

  // Flush matrix derived directly from the event rules
  function automatic logic [9:0] expComb(input vin_t x);
    logic pipe, exc;
    pipe = x.fence | x.fencei | x.sfence | x.hvvma | x.hgvma | x.csr | x.commit;
    exc  = x.ex | x.eret | x.dbg;
    return {pipe & ~exc, x.misp | pipe | exc, x.misp | pipe | exc, pipe | exc, pipe | exc,
            exc, x.fencei, x.sfence & ~x.v, (x.sfence & x.v) | x.hvvma, x.hgvma};
  endfunction

  // Behavioural model of one configuration for one clock
  task automatic modelStep(input int i, input bit start, input logic [1:0] a);
    bit accepted;
    int cmod;
    mto[i] = 0;
    cmod = (CFG_TO[i] > 0) ? (1 << $clog2(CFG_TO[i] + 1)) : 1;
    if (!mbusy[i]) begin
      if (start && CFG_WT[i] == 0) begin
        mbusy[i] = 1; mwait[i] = 0; mcur[i] = 0;
        mpend[i] = (CFG_SEQ[i] == 0) ? 2'b11 : 2'b00;
      end
    end else begin
      accepted = (CFG_SEQ[i] != 0) ? a[mcur[i]] : |(a & mpend[i]);
      if (CFG_TO[i] > 0 && mwait[i] == CFG_TO[i] && !accepted) begin
        mbusy[i] = 0; mpend[i] = '0; mto[i] = 1;
      end else if (CFG_SEQ[i] != 0) begin
        if (accepted) begin
          mwait[i] = 0;
          if (mcur[i] == NCH - 1) mbusy[i] = 0;
          else mcur[i] = mcur[i] + 1;
        end else begin
          mwait[i] = (mwait[i] + 1) % cmod;
        end
      end else begin
        mpend[i] = mpend[i] & ~a;
        mwait[i] = (mwait[i] + 1) % cmod;
        if (mpend[i] == 2'b00) mbusy[i] = 0;
      end
    end
  endtask

  function automatic logic [1:0] modelFlush(input int i);
    if (!mbusy[i]) return 2'b00;
    return (CFG_SEQ[i] != 0) ? (2'b01 << mcur[i]) : mpend[i];
  endfunction

  initial begin
    vin_t x;
    logic [1:0] a [NI];
    rst_n = 1'b0;
    clearInputs();

    vecs[0]  = '{13'b0_0_00000_00_000_0, 10'b00000_00000};
    vecs[1]  = '{13'b0_1_00000_00_000_0, 10'b01100_00000};
    vecs[2]  = '{13'b0_0_10000_00_000_0, 10'b11111_00000};
    vecs[3]  = '{13'b0_0_01000_00_000_0, 10'b11111_01000};
    vecs[4]  = '{13'b0_0_00100_00_000_0, 10'b11111_00100};
    vecs[5]  = '{13'b1_0_00100_00_000_0, 10'b11111_00010};
    vecs[6]  = '{13'b0_0_00010_00_000_0, 10'b11111_00010};
    vecs[7]  = '{13'b1_0_00001_00_000_0, 10'b11111_00001};
    vecs[8]  = '{13'b0_0_00000_10_000_0, 10'b11111_00000};
    vecs[9]  = '{13'b0_0_00000_01_000_0, 10'b11111_00000};
    vecs[10] = '{13'b0_0_00000_00_100_0, 10'b01111_10000};
    vecs[11] = '{13'b0_0_00000_00_010_0, 10'b01111_10000};
    vecs[12] = '{13'b0_0_00000_00_001_0, 10'b01111_10000};
    vecs[13] = '{13'b0_0_10000_00_100_0, 10'b01111_10000};
    vecs[14] = '{13'b0_0_01000_00_010_0, 10'b01111_11000};
    vecs[15] = '{13'b1_1_00100_00_000_0, 10'b11111_00010};
    vecs[16] = '{13'b0_0_00000_00_000_1, 10'b00000_00000};
    vecs[17] = '{13'b0_1_00011_00_000_0, 10'b11111_00011};

    // Reset state, including while reset is still asserted
    #2;
    for (int i = 0; i < NI; i++) checkOutput($sformatf("in_reset fc[%0d]", i), 32'(flush_cache[i]), 0);
    doReset();
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("reset fc[%0d]", i), 32'(flush_cache[i]), 0);
      checkOutput($sformatf("reset busy[%0d]", i), 32'(fence_busy[i]), 0);
      checkOutput($sformatf("reset halt[%0d]", i), 32'(halt[i]), 0);
      checkOutput($sformatf("reset to[%0d]", i), 32'(flush_timeout[i]), 0);
    end

    // Flush matrix vectors
    for (int k = 0; k < 18; k++) begin
      applyStimulus(vecs[k].in);
      #1;
      checkOutput($sformatf("matrix v%0d", k), 32'(combOut(0)), 32'(vecs[k].exp));
      checkOutput($sformatf("wt halt v%0d", k), 32'(halt[3]), 32'(vecs[k].in.haltcsr));
      checkOutput($sformatf("wt fc v%0d", k), 32'(flush_cache[3]), 0);
      tick();
    end

    // Parallel flush, timeout with no ack, sequential timeout, write-through idle
    doReset();
    for (int c = 0; c < 8; c++) begin
      clearInputs();
      fence = (c == 0);
      ack[0] = (c == 3) ? 2'b10 : (c == 5) ? 2'b01 : 2'b00;
      #1;
      checkOutput($sformatf("A fc0 c%0d", c), 32'(flush_cache[0]), 32'(A_FC0[c]));
      checkOutput($sformatf("A halt0 c%0d", c), 32'(halt[0]), 32'(A_HLT0[c]));
      checkOutput($sformatf("A fc2 c%0d", c), 32'(flush_cache[2]), 32'(A_FC2[c]));
      checkOutput($sformatf("A to2 c%0d", c), 32'(flush_timeout[2]), 32'(A_TO2[c]));
      checkOutput($sformatf("A halt2 c%0d", c), 32'(halt[2]), 32'(A_HLT0[c]));
      checkOutput($sformatf("A fc4 c%0d", c), 32'(flush_cache[4]), 32'(A_FC4[c]));
      checkOutput($sformatf("A to4 c%0d", c), 32'(flush_timeout[4]), 32'(A_TO4[c]));
      checkOutput($sformatf("A fc3 c%0d", c), 32'(flush_cache[3]), 0);
      checkOutput($sformatf("A busy3 c%0d", c), 32'(fence_busy[3]), 0);
      tick();
    end

    // Acks landing in the expiry cycle beat the timeout
    doReset();
    for (int c = 0; c < 8; c++) begin
      clearInputs();
      fence = (c == 0);
      ack[2] = (c == 5) ? 2'b11 : 2'b00;
      #1;
      checkOutput($sformatf("B fc2 c%0d", c), 32'(flush_cache[2]), (c >= 1 && c <= 5) ? 3 : 0);
      checkOutput($sformatf("B to2 c%0d", c), 32'(flush_timeout[2]), 0);
      checkOutput($sformatf("B busy2 c%0d", c), 32'(fence_busy[2]), (c >= 1 && c <= 5) ? 1 : 0);
      tick();
    end

    // Sequential flush, stray ack, fence while busy, ack in the request-rise cycle
    doReset();
    for (int c = 0; c < 9; c++) begin
      clearInputs();
      fence_i = (c == 0);
      fence = (c == 3);
      ack[1] = (c == 2) ? 2'b10 : (c == 4) ? 2'b01 : (c == 7) ? 2'b10 : 2'b00;
      ack[0] = (c == 1) ? 2'b11 : 2'b00;
      #1;
      checkOutput($sformatf("C fc1 c%0d", c), 32'(flush_cache[1]), 32'(C_FC1[c]));
      checkOutput($sformatf("C busy1 c%0d", c), 32'(fence_busy[1]), (c >= 1 && c <= 7) ? 1 : 0);
      checkOutput($sformatf("C icache c%0d", c), 32'(flush_icache[1]), (c == 0) ? 1 : 0);
      checkOutput($sformatf("C if1 c%0d", c), 32'(flush_if[1]), (c == 0 || c == 3) ? 1 : 0);
      if (c <= 4) checkOutput($sformatf("C fc0 c%0d", c), 32'(flush_cache[0]), 32'(C_FC0[c]));
      tick();
    end

    // Asynchronous reset while the second channel is being flushed
    doReset();
    fence = 1'b1;
    tick();
    clearInputs();
    ack[1] = 2'b01;
    #1;
    checkOutput("D fc1 c1", 32'(flush_cache[1]), 1);
    tick();
    clearInputs();
    #1;
    checkOutput("D fc1 c2", 32'(flush_cache[1]), 2);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("D fc1 async", 32'(flush_cache[1]), 0);
    checkOutput("D busy1 async", 32'(fence_busy[1]), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checkOutput($sformatf("D fc1 post%0d", c), 32'(flush_cache[1]), 0);
      checkOutput($sformatf("D busy1 post%0d", c), 32'(fence_busy[1]), 0);
    end

    // Fence together with an exception still starts the cache flush
    doReset();
    fence = 1'b1;
    ex_valid = 1'b1;
    #1;
    checkOutput("E set_pc", 32'(set_pc_commit[0]), 0);
    checkOutput("E bp", 32'(flush_bp[0]), 1);
    tick();
    clearInputs();
    #1;
    checkOutput("E busy0", 32'(fence_busy[0]), 1);
    checkOutput("E fc0", 32'(flush_cache[0]), 3);

    // Randomized traffic against the behavioural model
    doReset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NI; i++) begin
        checkOutput($sformatf("R fc[%0d] cyc%0d", i, cyc), 32'(flush_cache[i]), 32'(modelFlush(i)));
        checkOutput($sformatf("R busy[%0d] cyc%0d", i, cyc), 32'(fence_busy[i]), 32'(mbusy[i]));
        checkOutput($sformatf("R to[%0d] cyc%0d", i, cyc), 32'(flush_timeout[i]), 32'(mto[i]));
      end
      x = '0;
      x.v       = 1'($urandom_range(0, 1));
      x.misp    = ($urandom_range(0, 9) == 0);
      x.fence   = ($urandom_range(0, 7) == 0);
      x.fencei  = ($urandom_range(0, 7) == 0);
      x.sfence  = ($urandom_range(0, 9) == 0);
      x.hvvma   = ($urandom_range(0, 9) == 0);
      x.hgvma   = ($urandom_range(0, 9) == 0);
      x.csr     = ($urandom_range(0, 9) == 0);
      x.commit  = ($urandom_range(0, 9) == 0);
      x.ex      = ($urandom_range(0, 9) == 0);
      x.eret    = ($urandom_range(0, 9) == 0);
      x.dbg     = ($urandom_range(0, 9) == 0);
      x.haltcsr = ($urandom_range(0, 5) == 0);
      applyStimulus(x);
      rb.pc = {$urandom, $urandom};
      rb.valid = 1'($urandom_range(0, 1));
      for (int i = 0; i < NI; i++) begin
        a[i] = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
        ack[i] = a[i];
      end
      #1;
      checkOutput($sformatf("R comb cyc%0d", cyc), 32'(combOut(0)), 32'(expComb(x)));
      for (int i = 0; i < NI; i++) begin
        checkOutput($sformatf("R halt[%0d] cyc%0d", i, cyc), 32'(halt[i]), 32'(x.haltcsr | mbusy[i]));
        modelStep(i, x.fence | x.fencei, a[i]);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flush_sequencer.md
# flush_sequencer

Parametrised pipeline flush controller for the CVA6 core. Decodes fences, exceptions, CSR side-effects and mispredicts into pipeline, branch-predictor, icache and TLB flush strobes. Drives a configurable number of write-back cache flush channels, either in parallel or in sequence, with an optional acknowledge timeout. Sits between commit/CSR and frontend/issue/LSU/cache subsystem.

## Interface
Parameters:
- NrCacheChans, 2: write-back cache flush channels (index 0 = innermost, e.g. D$; 1 = L2).
- WtDcache, 0: 1 = write-through hierarchy; fences never flush caches, FSM stays IDLE.
- SeqMode, 0: 0 = all channels flushed in parallel; 1 = one at a time, ascending index.
- TimeoutCycles, 0: 0 disables timeout; else max wait per channel (SeqMode=1) or per fence (SeqMode=0).

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- v_i  in  1  virtualization mode
- resolved_branch_i  in  bp_resolve_t  only .is_mispredict used
- fence_i / fence_i_i / sfence_vma_i / hfence_vvma_i / hfence_gvma_i  in  1 each  fence strobes from commit
- flush_csr_i, flush_commit_i, ex_valid_i, eret_i, set_debug_pc_i, halt_csr_i  in  1 each
- flush_cache_ack_i  in  NrCacheChans  per-channel one-cycle done pulse
- set_pc_commit_o, flush_if_o, flush_unissued_instr_o, flush_id_o, flush_ex_o, flush_bp_o, flush_icache_o  out  1 each
- flush_tlb_o, flush_tlb_vvma_o, flush_tlb_gvma_o  out  1 each
- flush_cache_o  out  NrCacheChans  registered per-channel flush request
- halt_o  out  1  halt commit
- fence_busy_o  out  1  cache flush in progress
- flush_timeout_o  out  1  one-cycle pulse on timeout abort

## Operation
- Combinational flush matrix, same cycle as inputs, OR-combined:
  - mispredict: if + unissued.
  - fence/fence.i/sfence/hfence/flush_csr/flush_commit: set_pc_commit, if, unissued, id, ex. fence.i also icache.
  - sfence.vma: flush_tlb_o if !v_i else flush_tlb_vvma_o. hfence.vvma: vvma. hfence.gvma: gvma.
  - ex_valid/eret/set_debug_pc: if, unissued, id, ex, bp; forces set_pc_commit_o=0 (highest priority).
- FSM states: IDLE, FLUSH_PAR, FLUSH_SEQ.
  - IDLE: fence or fence.i (WtDcache=0) -> FLUSH_PAR (SeqMode=0, pending mask = all ones) or FLUSH_SEQ (index=0).
  - FLUSH_PAR: flush_cache_o = pending mask. Ack on pending channel clears its bit. Mask empty -> IDLE.
  - FLUSH_SEQ: flush_cache_o = onehot(index). Ack on index -> index+1; ack on last index -> IDLE.
- Acks on non-requested channels ignored. Fence while not IDLE: pipeline flushes still asserted, cache sequence not restarted.
- Timeout (TimeoutCycles>0): counter cleared on entry and on each accepted ack in FLUSH_SEQ. Counter reaching TimeoutCycles with no ack -> all requests dropped, IDLE, flush_timeout_o pulsed.
- halt_o = halt_csr_i | (state != IDLE). fence_busy_o = (state != IDLE).

## Timing
- Reset: state IDLE, pending mask 0, index 0, counter 0, flush_cache_o 0, flush_timeout_o 0. Combinational outputs follow inputs.
- Fence at cycle 0 -> state and flush_cache_o valid at cycle 1; halt_o high from cycle 1.
- Ack at cycle k -> that request low at k+1. Final ack at k -> IDLE, halt_o low, flush_cache_o all 0 at k+1. In SeqMode, next channel raised at k+1.
- Ack at cycle 1 (same cycle as request rise) is accepted.
- Counter width $clog2(TimeoutCycles+1). Expiry at count == TimeoutCycles, with no saturation beyond. An ack in the expiry cycle wins over timeout.
- Reset mid-flush: all requests drop immediately (async).

## Structure
- flush_state_e, and the mask/index width localparams derived from NrCacheChans, go in ariane_pkg.
- Sub-module cache_flush_fsm holds the FSM, mask/index and timeout counter. Top level holds the combinational flush matrix and halt OR.

## Test plan
- N=2, SeqMode=0: fence at c0; acks ch1@c3, ch0@c5 -> flush_cache_o=11 c1–c3, 01 c4–c5, 00 c6; halt_o high c1–c5.
- N=2, SeqMode=1: fence.i at c0 -> flush_icache_o c0; flush_cache_o=01 c1; ack@c4 -> 10 c5; ack@c7 -> 00 c8.
- TimeoutCycles=4, SeqMode=0, no ack -> flush_timeout_o pulse one cycle, requests 0 and halt_o low by c6; ack in expiry cycle instead -> no timeout pulse.
- WtDcache=1: fence -> pipeline strobes c0, flush_cache_o stays 0, halt_o == halt_csr_i.
- sfence.vma with v_i=0/1 -> flush_tlb_o / flush_tlb_vvma_o at c0. fence + ex_valid same cycle -> set_pc_commit_o=0, flush_bp_o=1, FSM still enters flush.
- rst_ni low during FLUSH_SEQ index 1 -> flush_cache_o 0 immediately; after release, state is IDLE.
